// File: rtl/bcd_scan_ctrl_if.sv
// Bundle carrying the load path in and the registered scan outputs back out.
// The scan controller takes the slave modport; its driver takes the master modport.
interface bcd_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic                      lz_blank_en;
    logic [3:0]                bcd_out;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic                      frame_done;

    modport master (
        output load,
        output digits_in,
        output lz_blank_en,
        input  bcd_out,
        input  digit_en,
        input  frame_done
    );

    modport slave (
        input  load,
        input  digits_in,
        input  lz_blank_en,
        output bcd_out,
        output digit_en,
        output frame_done
    );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// Multiplexed scan of a packed BCD value onto a 4-bit bus with one-hot digit enables and an all-off guard between digits.
// Latency: outputs registered; a load reaches the display at the next frame boundary; first digit shows BLANK_CYCLES after reset.
// Backpressure: none; loads are always accepted, the last load in a frame wins and a load on the boundary cycle wins outright.
module bcd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_scan_ctrl_if.slave  bus
);
    localparam int MAX_PH = (BLANK_CYCLES > REFRESH_DIV) ? BLANK_CYCLES : REFRESH_DIV;
    localparam int CNT_W  = $clog2(MAX_PH) + 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int VAL_W  = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("bcd_scan_ctrl: NUM_DIGITS must be 2..8");
        end
        if (REFRESH_DIV < 1 || BLANK_CYCLES < 1) begin : g_bad_timing
            $error("bcd_scan_ctrl: REFRESH_DIV and BLANK_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [VAL_W-1:0]       active_q, active_d;
    logic [VAL_W-1:0]       pending_q, pending_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   lz_q, lz_d;
    logic [3:0]             bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]  en_q, en_d;
    logic                   fd_q, fd_d;

    logic                   boundary;
    logic                   zero_run;
    logic [NUM_DIGITS-1:0]  blank_mask;
    logic [3:0]             nib_d;

    // Leading-zero mask depends only on the active value and the frame-latched enable,
    // so it holds steady for a whole frame. Digit 0 is never blanked.
    always_comb begin
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run      = zero_run & (active_q[4*k +: 4] == 4'h0);
            blank_mask[k] = lz_q & zero_run;
        end
    end

    // Phase sequencing: BLANK(idx) -> SHOW(idx) -> BLANK(idx+1); the wrap out of the
    // last digit's SHOW is the frame boundary.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + 1'b1;
        boundary = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Value path: updates land in the active register only on the boundary edge.
    always_comb begin
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        lz_d       = lz_q;
        if (boundary) begin
            if (bus.load) begin
                active_d = bus.digits_in;
            end else if (pend_vld_q) begin
                active_d = pending_q;
            end
            pend_vld_d = 1'b0;
            lz_d       = bus.lz_blank_en;
        end else if (bus.load) begin
            pending_d  = bus.digits_in;
            pend_vld_d = 1'b1;
        end
    end

    // Outputs are computed from the next phase so the registered values line up with
    // the state they describe. Entering SHOW never coincides with an active update.
    always_comb begin
        nib_d = 4'hF;
        en_d  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == idx_d) begin
                nib_d   = blank_mask[k] ? 4'hF : active_q[4*k +: 4];
                en_d[k] = (state_d == SHOW);
            end
        end
        bcd_d = (state_d == SHOW) ? nib_d : 4'hF;
        fd_d  = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BLANK;
            idx_q      <= '0;
            cnt_q      <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            lz_q       <= 1'b0;
            bcd_q      <= 4'hF;
            en_q       <= '0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            lz_q       <= lz_d;
            bcd_q      <= bcd_d;
            en_q       <= en_d;
            fd_q       <= fd_d;
        end
    end

    assign bus.bcd_out    = bcd_q;
    assign bus.digit_en   = en_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl with 4 digits, 2 blank + 4 show cycles per slot (24-cycle frame).
module tb_bcd_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    bcd_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one 24-cycle frame starting from BLANK(0); exp_val nibble k is the expected
    // bcd_out during digit k's SHOW. Loads at step la/lb are sampled on the following edge;
    // bnd=1 drives a load that is sampled on the boundary edge itself.
    task automatic run_frame(input string tag, input logic [15:0] exp_val, input logic lz,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb,
                             input logic bnd, input logic [15:0] vbnd);
        int         t;
        int         slot;
        int         off;
        logic       show;
        logic [3:0] een;
        logic [3:0] ebcd;
        bus.lz_blank_en = lz;
        for (int i = 1; i <= 24; i++) begin
            step();
            t    = i % 24;
            slot = t / 6;
            off  = t % 6;
            show = (off >= BC);
            een  = show ? 4'(1 << slot) : 4'h0;
            ebcd = show ? exp_val[slot*4 +: 4] : 4'hF;
            chk($sformatf("%s_s%0d_en", tag, i), 32'(bus.digit_en), 32'(een));
            chk($sformatf("%s_s%0d_bcd", tag, i), 32'(bus.bcd_out), 32'(ebcd));
            chk($sformatf("%s_s%0d_fd", tag, i), 32'(bus.frame_done), 32'(i == 24));
            bus.load = 1'b0;
            if (i == la) begin
                bus.load = 1'b1; bus.digits_in = va;
            end
            if (i == lb) begin
                bus.load = 1'b1; bus.digits_in = vb;
            end
            if (bnd && i == 23) begin
                bus.load = 1'b1; bus.digits_in = vbnd;
            end
        end
        bus.load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load        = 1'b0;
        bus.digits_in   = '0;
        bus.lz_blank_en = 1'b0;
        rst_n           = 1'b0;
        step();
        step();
        chk("rst_en", 32'(bus.digit_en), 32'h0);
        chk("rst_bcd", 32'(bus.bcd_out), 32'hF);
        chk("rst_fd", 32'(bus.frame_done), 32'h0);
        rst_n = 1'b1;

        // Power-up frame of zeros; mid-frame load must not disturb it.
        run_frame("f1", 16'h0000, 1'b0, 10, 16'h1234, 0, 16'h0, 1'b0, 16'h0);
        // Loaded value appears; lz requested mid-frame only takes effect next boundary.
        run_frame("f2", 16'h1234, 1'b1, 5, 16'h0070, 0, 16'h0, 1'b0, 16'h0);
        run_frame("f3", 16'hFF70, 1'b1, 3, 16'h0000, 0, 16'h0, 1'b0, 16'h0);
        // Two mid-frame loads then one on the boundary cycle: the boundary load wins.
        run_frame("f4", 16'hFFF0, 1'b0, 2, 16'h1111, 12, 16'h2222, 1'b1, 16'h3333);
        run_frame("f5", 16'h3333, 1'b0, 7, 16'h00A5, 0, 16'h0, 1'b0, 16'h0);
        // Invalid nibble A forwarded unchanged, leading zeros shown with lz off.
        run_frame("f6", 16'h00A5, 1'b0, 0, 16'h0, 0, 16'h0, 1'b0, 16'h0);

        // Partial frame: pend a load, reach SHOW of digit 2, then reset asynchronously.
        for (int i = 1; i <= 14; i++) begin
            step();
            bus.load = 1'b0;
            if (i == 3) begin
                bus.load = 1'b1; bus.digits_in = 16'h5678;
            end
        end
        chk("pre_rst_en", 32'(bus.digit_en), 32'h4);
        chk("pre_rst_bcd", 32'(bus.bcd_out), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(bus.digit_en), 32'h0);
        chk("mid_rst_bcd", 32'(bus.bcd_out), 32'hF);
        chk("mid_rst_fd", 32'(bus.frame_done), 32'h0);
        #2 rst_n = 1'b1;

        // Restart from digit 0 with active cleared and the pending load discarded.
        run_frame("f7", 16'h0000, 1'b0, 0, 16'h0, 0, 16'h0, 1'b0, 16'h0);
        run_frame("f8", 16'h0000, 1'b0, 0, 16'h0, 0, 16'h0, 1'b0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
